// File: rtl/mem_pkg.sv
// Shared types and funct3 encodings for the memory-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_load_align.sv
// Shifts the raw cache word down by the byte offset and sign/zero-extends per funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = raw >> {offset, 3'b000};

  always_comb begin
    data = sh;
    case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   data = {24'h0, sh[7:0]};
      F3_HU:   data = {16'h0, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-cache controller: issues one request per load/store, stalls
// the pipeline until the cache responds, and holds the aligned load result.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid,
  input  logic        MEM_is_load,
  input  logic        MEM_is_store,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_rs2,
  input  logic        advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  mem_state_t  state, state_nxt;
  logic        is_mem, f3_bad, align_bad, access, issue, finish;
  logic [3:0]  be_c;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] ld_data;

  assign is_mem = MEM_valid & (MEM_is_load | MEM_is_store);

  // Stores only have B/H/W; loads additionally have BU/HU.
  assign f3_bad = MEM_is_store ? (MEM_funct3[2] | (MEM_funct3[1:0] == 2'b11))
                               : ((MEM_funct3[1:0] == 2'b11) | (MEM_funct3 == 3'b110));
  assign align_bad = ((MEM_funct3[1:0] == 2'b01) & MEM_alu_out[0]) |
                     ((MEM_funct3[1:0] == 2'b10) & (MEM_alu_out[1:0] != 2'b00));

  assign mem_misaligned = is_mem & (f3_bad | align_bad);
  assign access         = is_mem & ~mem_misaligned;
  assign mem_stall      = access & (state != DONE);

  always_comb begin
    be_c = 4'b0000;
    if (MEM_is_store) begin
      case (MEM_funct3[1:0])
        2'b00:   be_c = 4'b0001 << MEM_alu_out[1:0];
        2'b01:   be_c = 4'b0011 << {MEM_alu_out[1], 1'b0};
        2'b10:   be_c = 4'b1111;
        default: be_c = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (access) begin
        state_nxt = BUSY;
        issue     = 1'b1;
      end
      BUSY: if (dmem_resp) begin
        state_nxt = DONE;
        finish    = 1'b1;
      end
      DONE: if (advance) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  mem_load_align u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .raw    (dmem_rdata),
    .data   (ld_data)
  );

  // funct3/offset are latched at issue so extraction does not depend on upstream holding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 32'h0;
      dmem_byte_enable <= 4'h0;
      dmem_wdata       <= 32'h0;
      MEM_rdata        <= 32'h0;
      f3_q             <= 3'b000;
      off_q            <= 2'b00;
    end else begin
      if (issue) begin
        dmem_read        <= MEM_is_load;
        dmem_write       <= MEM_is_store & ~MEM_is_load;
        dmem_address     <= {MEM_alu_out[31:2], 2'b00};
        dmem_byte_enable <= be_c;
        dmem_wdata       <= MEM_rs2 << {MEM_alu_out[1:0], 3'b000};
        f3_q             <= MEM_funct3;
        off_q            <= MEM_alu_out[1:0];
      end
      if (finish) begin
        dmem_read  <= 1'b0;
        dmem_write <= 1'b0;
        if (dmem_read) MEM_rdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_valid, MEM_is_load, MEM_is_store, advance;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_out, MEM_rs2;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata, MEM_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        mem_stall, mem_misaligned;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .reset            (reset),
    .MEM_valid        (MEM_valid),
    .MEM_is_load      (MEM_is_load),
    .MEM_is_store     (MEM_is_store),
    .MEM_funct3       (MEM_funct3),
    .MEM_alu_out      (MEM_alu_out),
    .MEM_rs2          (MEM_rs2),
    .advance          (advance),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .MEM_rdata        (MEM_rdata),
    .mem_stall        (mem_stall),
    .mem_misaligned   (mem_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    MEM_valid    = 1'b1;
    MEM_is_load  = ld;
    MEM_is_store = st;
    MEM_funct3   = f3;
    MEM_alu_out  = a;
    MEM_rs2      = d;
  endtask

  task automatic idle_in;
    MEM_valid    = 1'b0;
    MEM_is_load  = 1'b0;
    MEM_is_store = 1'b0;
    advance      = 1'b0;
  endtask

  // One full memory op: IDLE -> BUSY (lat cycles) -> DONE -> advance -> IDLE.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                        input int lat, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rdata);
    set_op(ld, st, f3, a, d);
    #1;
    chk({tag, "_stall_idle"}, 32'(mem_stall), 32'd1);
    chk({tag, "_misal"}, 32'(mem_misaligned), 32'd0);
    step;
    chk({tag, "_rd"}, 32'(dmem_read), 32'(ld));
    chk({tag, "_wr"}, 32'(dmem_write), 32'(st));
    chk({tag, "_addr"}, dmem_address, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(dmem_byte_enable), 32'(exp_be));
    if (st) chk({tag, "_wdata"}, dmem_wdata, exp_wd);
    for (int i = 1; i < lat; i++) begin
      step;
      chk({tag, "_hold_strobe"}, 32'(dmem_read | dmem_write), 32'd1);
      chk({tag, "_hold_stall"}, 32'(mem_stall), 32'd1);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rd;
    #1;
    chk({tag, "_stall_resp"}, 32'(mem_stall), 32'd1);
    step;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_done_strobe"}, 32'(dmem_read | dmem_write), 32'd0);
    chk({tag, "_rdata"}, MEM_rdata, exp_rdata);
    advance = 1'b1;
    step;
    idle_in;
    #1;
    chk({tag, "_after_stall"}, 32'(mem_stall), 32'd0);
  endtask

  logic        mis_ld [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        mis_st [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0]  mis_f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
  logic [31:0] mis_a  [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h103};

  initial begin
    reset      = 1'b0;
    idle_in;
    MEM_funct3 = 3'b000;
    MEM_alu_out = 32'h0;
    MEM_rs2    = 32'h0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    #3;
    chk("rst_rd", 32'(dmem_read), 32'd0);
    chk("rst_wr", 32'(dmem_write), 32'd0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_be", 32'(dmem_byte_enable), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", MEM_rdata, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_misal", 32'(mem_misaligned), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step;

    // Non-memory instruction never stalls.
    MEM_valid = 1'b1;
    #1;
    chk("nonmem_stall", 32'(mem_stall), 32'd0);
    step;
    chk("nonmem_rd", 32'(dmem_read), 32'd0);
    idle_in;

    run_op("lw",  1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_op("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 3, 4'b0000, 32'h0, 32'h00000080);
    run_op("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1, 4'b0000, 32'h0, 32'hFFFF80FF);
    run_op("sb",  1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 2, 4'b0010, 32'h0000AB00, 32'hFFFF80FF);
    run_op("sh",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h12345678, 1, 4'b1100, 32'hABCD0000, 32'hFFFF80FF);
    run_op("sw",  1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h12345678, 1, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF);
    run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h1234F00D, 1, 4'b0000, 32'h0, 32'h0000F00D);

    // Rejected accesses: no request, no stall.
    for (int i = 0; i < 5; i++) begin
      set_op(mis_ld[i], mis_st[i], mis_f3[i], mis_a[i], 32'hFFFFFFFF);
      #1;
      chk($sformatf("mis%0d_flag", i), 32'(mem_misaligned), 32'd1);
      chk($sformatf("mis%0d_stall", i), 32'(mem_stall), 32'd0);
      step;
      chk($sformatf("mis%0d_strobe", i), 32'(dmem_read | dmem_write), 32'd0);
      idle_in;
      #1;
      chk($sformatf("mis%0d_clear", i), 32'(mem_misaligned), 32'd0);
    end

    // DONE holds the result without advance; stray responses ignored.
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    step;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h11223344;
    step;
    dmem_resp  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d_stall", i), 32'(mem_stall), 32'd0);
      chk($sformatf("hold%0d_rdata", i), MEM_rdata, 32'h11223344);
      chk($sformatf("hold%0d_rd", i), 32'(dmem_read), 32'd0);
      dmem_resp  = (i == 1);
      dmem_rdata = 32'hFFFFFFFF;
      step;
      dmem_resp  = 1'b0;
    end
    advance = 1'b1;
    step;
    advance = 1'b0;
    chk("hold_back_idle_stall", 32'(mem_stall), 32'd1);
    chk("hold_back_idle_rd", 32'(dmem_read), 32'd0);
    chk("hold_back_idle_rdata", MEM_rdata, 32'h11223344);
    idle_in;
    #1;

    // Reset during BUSY: strobes drop at once, late response ignored.
    set_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    step;
    chk("rb_rd_pre", 32'(dmem_read), 32'd1);
    reset = 1'b0;
    #1;
    chk("rb_rd", 32'(dmem_read), 32'd0);
    chk("rb_addr", dmem_address, 32'h0);
    chk("rb_rdata", MEM_rdata, 32'h0);
    idle_in;
    @(negedge clk);
    reset = 1'b1;
    step;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h55555555;
    step;
    dmem_resp  = 1'b0;
    chk("rb_late_rdata", MEM_rdata, 32'h0);
    chk("rb_late_rd", 32'(dmem_read), 32'd0);
    chk("rb_late_stall", 32'(mem_stall), 32'd0);
    run_op("post_rst", 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADCAFE, 1, 4'b0000, 32'h0, 32'h0BADCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-cache access controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register: issues load/store requests to the data cache, holds the pipeline with `mem_stall` until the cache responds, and delivers the aligned, extended load result on `MEM_rdata` for capture into the MEM/WB register.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data, 4-bit byte enable.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately
- `MEM_valid`  in  1  instruction in MEM is valid
- `MEM_is_load`  in  1  instruction is a load
- `MEM_is_store`  in  1  instruction is a store
- `MEM_funct3`  in  3  RISC-V funct3 (size/sign)
- `MEM_alu_out`  in  32  effective byte address
- `MEM_rs2`  in  32  store data, unshifted
- `advance`  in  1  global pipeline load; high when the MEM/WB register captures this cycle
- `dmem_read` / `dmem_write`  out  1  cache request strobes (registered)
- `dmem_address`  out  32  word-aligned address, {addr[31:2],2'b00} (registered)
- `dmem_byte_enable`  out  4  store byte mask (registered)
- `dmem_wdata`  out  32  store data lane-shifted (registered)
- `dmem_resp`  in  1  cache completion, one-cycle pulse
- `dmem_rdata`  in  32  cache read word, valid with `dmem_resp`
- `MEM_rdata`  out  32  aligned, extended load result (registered)
- `mem_stall`  out  1  hold all upstream stages and MEM/WB (combinational)
- `mem_misaligned`  out  1  access rejected this cycle (combinational)

## Operation
- FSM states IDLE, BUSY, DONE.
- Access = `MEM_valid & (MEM_is_load | MEM_is_store) & ~mem_misaligned`.
- IDLE: on access, register address/byte enable/wdata, set `dmem_read` (load) or `dmem_write` (store), go BUSY. Otherwise stay.
- BUSY: request outputs held stable. On `dmem_resp`: drop strobes, capture extracted load data into `MEM_rdata` (stores leave it unchanged), go DONE.
- DONE: if `advance`, go IDLE; else stay DONE (result held).
- `mem_stall` = access & state != DONE. Non-memory instructions never stall.
- Byte enable: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111; loads 4'b0000. wdata = rs2 << (8*a[1:0]).
- Load extract from `dmem_rdata` >> (8*a[1:0]): LB (000) sign-extend byte, LH (001) sign-extend half, LW (010) word, LBU (100) / LHU (101) zero-extend.
- Misaligned: half with a[0]=1, word with a[1:0]!=0, or funct3 not in {000,001,010,100,101} (stores: only 000–010 legal). No request issued, no stall, `mem_misaligned`=1 while the instruction sits in MEM.
- `dmem_resp` in IDLE or DONE: ignored.

## Timing
- Reset values: state IDLE; `dmem_read`, `dmem_write` 0; `dmem_address`, `dmem_wdata`, `MEM_rdata` 0; `dmem_byte_enable` 0. Combinational outputs follow.
- Cycle 0: access seen in IDLE, stall=1. Cycle 1: strobe high. Response at cycle k≥1 → cycle k+1 DONE, stall=0, `MEM_rdata` valid, MEM/WB captures if `advance`. Minimum 3 cycles in MEM per memory op; single-cycle if `dmem_resp` is never slower than 1 cycle is not supported.
- Back-to-back memory ops: DONE→IDLE→BUSY; one idle cycle between requests, strobe drops for ≥1 cycle.
- Reset asserted in BUSY: strobes drop asynchronously; a subsequent in-flight `dmem_resp` is ignored.

## Structure
- Package `mem_pkg`: `mem_state_t` enum (IDLE, BUSY, DONE); funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- One combinational sub-module `mem_load_align` (funct3, offset, raw word → extended 32-bit data); FSM, mask/shift logic in top.

## Test plan
- LW at 0x100, resp after 2 cycles with 0xDEADBEEF → `dmem_address`=0x100, stall high 3 cycles, `MEM_rdata`=0xDEADBEEF in DONE.
- LB at 0x103, rdata 0x80FF_0000 → `MEM_rdata`=0xFFFFFF80; LBU same → 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB at 0x201, rs2=0x000000AB → byte_enable 4'b0010, wdata 0x0000AB00, `dmem_write` held until resp, `MEM_rdata` unchanged.
- LW at 0x102 → `mem_misaligned`=1, no strobe, `mem_stall`=0; LH at 0x101 same.
- DONE with `advance`=0 for 3 cycles → stays DONE, `MEM_rdata` stable, no new request; then `advance`=1 → IDLE.
- Reset low in BUSY, `dmem_resp` pulses after release → all outputs zero, state IDLE, response ignored.
